// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: NOP word, FSM states and
// performance counter widths.
package pipe_ctrl_pkg;

    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam int          STALL_CNT_W = 32;
    localparam int          FLUSH_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MD_WAIT    = 2'd1,
        ST_IF_WAIT    = 2'd2,
        ST_REDIR_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments by one when inc is high, sticks at all-ones.
module sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: Mealy FSM generating stall/flush/redirect controls
// for jumps, load-use, multi-cycle mul/div and fetch misses, plus perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_en_i,
    input  logic [31:0]            jump_addr_i,
    input  logic                   ld_use_i,
    input  logic                   md_start_i,
    input  logic                   md_done_i,
    input  logic                   imem_ready_i,
    output logic                   stall_pc_o,
    output logic                   stall_if_id_o,
    output logic                   stall_id_ex_o,
    output logic                   flush_if_id_o,
    output logic                   flush_id_ex_o,
    output logic                   redirect_en_o,
    output logic [31:0]            redirect_addr_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);

    state_t      state, state_nxt;
    logic [31:0] cap_addr;
    logic        cap_load;
    logic        jump_acc;

    logic        stall_pc, stall_if_id, stall_id_ex;
    logic        flush_if_id, flush_id_ex;
    logic        redirect_en;
    logic [31:0] redirect_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            cap_addr <= '0;
        end else begin
            state <= state_nxt;
            if (cap_load) begin
                cap_addr <= jump_addr_i;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cap_load      = 1'b0;
        jump_acc      = 1'b0;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = cap_addr;

        case (state)
            ST_RUN, ST_IF_WAIT: begin
                if (jump_en_i) begin
                    jump_acc      = 1'b1;
                    redirect_en   = 1'b1;
                    redirect_addr = jump_addr_i;
                    flush_if_id   = 1'b1;
                    flush_id_ex   = 1'b1;
                    if (imem_ready_i) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_REDIR_HOLD;
                        cap_load  = 1'b1;
                    end
                end else if (md_start_i) begin
                    // A unit that finishes in its issue cycle needs no stall.
                    if (md_done_i) begin
                        state_nxt = ST_RUN;
                    end else begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        stall_id_ex = 1'b1;
                        state_nxt   = ST_MD_WAIT;
                    end
                end else if (ld_use_i) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (!imem_ready_i) begin
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                    state_nxt   = ST_IF_WAIT;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_MD_WAIT: begin
                if (md_done_i) begin
                    state_nxt = ST_RUN;
                end else begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                end
            end
            ST_REDIR_HOLD: begin
                redirect_en = 1'b1;
                flush_if_id = 1'b1;
                if (imem_ready_i) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Reset must silence the controls combinationally, not at the next edge.
    assign stall_pc_o      = stall_pc    & ~rst;
    assign stall_if_id_o   = stall_if_id & ~rst;
    assign stall_id_ex_o   = stall_id_ex & ~rst;
    assign flush_if_id_o   = flush_if_id & ~rst;
    assign flush_id_ex_o   = flush_id_ex & ~rst;
    assign redirect_en_o   = redirect_en & ~rst;
    assign redirect_addr_o = rst ? 32'h0 : redirect_addr;

    sat_cnt #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_pc),
        .cnt (stall_cnt_o)
    );

    sat_cnt #(
        .WIDTH (FLUSH_CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (jump_acc),
        .cnt (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: jump/redirect, mul/div stall,
// load-use, fetch miss, counter saturation and asynchronous reset.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ld_use_i;
    logic        md_start_i;
    logic        md_done_i;
    logic        imem_ready_i;
    logic        stall_pc_o, stall_if_id_o, stall_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o;
    logic        redirect_en_o;
    logic [31:0] redirect_addr_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i),
        .ld_use_i        (ld_use_i),
        .md_start_i      (md_start_i),
        .md_done_i       (md_done_i),
        .imem_ready_i    (imem_ready_i),
        .stall_pc_o      (stall_pc_o),
        .stall_if_id_o   (stall_if_id_o),
        .stall_id_ex_o   (stall_id_ex_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .redirect_en_o   (redirect_en_o),
        .redirect_addr_o (redirect_addr_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs checked a few ns later, well before the following edge.
    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic idle_inputs;
        jump_en_i    = 1'b0;
        jump_addr_i  = 32'h0;
        ld_use_i     = 1'b0;
        md_start_i   = 1'b0;
        md_done_i    = 1'b0;
        imem_ready_i = 1'b1;
    endtask

    function automatic logic [5:0] ctl_vec();
        return {stall_pc_o, stall_if_id_o, stall_id_ex_o,
                flush_if_id_o, flush_id_ex_o, redirect_en_o};
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_ctl", {26'h0, ctl_vec()}, 32'h0);
        chk("rst_addr", redirect_addr_o, 32'h0);
        next_cyc();
        next_cyc();
        chk("rst_scnt", stall_cnt_o, 32'h0);
        chk("rst_fcnt", {16'h0, flush_cnt_o}, 32'h0);
        rst = 1'b0;
        next_cyc();
        settle();
        chk("idle_ctl", {26'h0, ctl_vec()}, 32'h0);

        // Jump with fetch ready: single-cycle redirect
        next_cyc();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h8000_0040;
        settle();
        chk("j1_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b000111});
        chk("j1_addr", redirect_addr_o, 32'h8000_0040);
        chk("j1_fcnt_pre", {16'h0, flush_cnt_o}, 32'h0);
        next_cyc();
        idle_inputs();
        settle();
        chk("j1_after_ctl", {26'h0, ctl_vec()}, 32'h0);
        chk("j1_fcnt", {16'h0, flush_cnt_o}, 32'h1);
        chk("j1_after_addr", redirect_addr_o, 32'h0);

        // Jump while fetch stalled for 3 cycles: redirect held 4 cycles
        next_cyc();
        jump_en_i    = 1'b1;
        jump_addr_i  = 32'h8000_1000;
        imem_ready_i = 1'b0;
        settle();
        chk("j2_c1_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b000111});
        chk("j2_c1_addr", redirect_addr_o, 32'h8000_1000);
        next_cyc();
        jump_addr_i = 32'h1234_5678;
        settle();
        chk("j2_c2_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b000101});
        chk("j2_c2_addr", redirect_addr_o, 32'h8000_1000);
        next_cyc();
        jump_en_i   = 1'b0;
        jump_addr_i = 32'h0;
        settle();
        chk("j2_c3_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b000101});
        next_cyc();
        imem_ready_i = 1'b1;
        settle();
        chk("j2_c4_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b000101});
        chk("j2_c4_addr", redirect_addr_o, 32'h8000_1000);
        next_cyc();
        settle();
        chk("j2_run_ctl", {26'h0, ctl_vec()}, 32'h0);
        chk("j2_run_addr", redirect_addr_o, 32'h8000_1000);
        chk("j2_fcnt", {16'h0, flush_cnt_o}, 32'h2);
        chk("j2_scnt", stall_cnt_o, 32'h0);

        // Mul/div: start, done five cycles later
        next_cyc();
        md_start_i = 1'b1;
        settle();
        chk("md_c1", {26'h0, ctl_vec()}, {26'h0, 6'b111000});
        for (int i = 2; i <= 5; i++) begin
            next_cyc();
            md_start_i = 1'b0;
            ld_use_i   = (i == 3);
            jump_en_i  = (i == 4);
            settle();
            chk($sformatf("md_c%0d", i), {26'h0, ctl_vec()}, {26'h0, 6'b111000});
        end
        next_cyc();
        idle_inputs();
        md_done_i = 1'b1;
        settle();
        chk("md_done_ctl", {26'h0, ctl_vec()}, 32'h0);
        chk("md_scnt", stall_cnt_o, 32'd5);
        chk("md_fcnt", {16'h0, flush_cnt_o}, 32'h2);

        // Start and done together: no stall, stays in RUN
        next_cyc();
        md_start_i = 1'b1;
        md_done_i  = 1'b1;
        settle();
        chk("md_same_ctl", {26'h0, ctl_vec()}, 32'h0);
        next_cyc();
        idle_inputs();
        settle();
        chk("md_same_next", {26'h0, ctl_vec()}, 32'h0);

        // Load-use bubble, one cycle only
        next_cyc();
        ld_use_i = 1'b1;
        settle();
        chk("ld_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b110010});
        next_cyc();
        ld_use_i = 1'b0;
        settle();
        chk("ld_next", {26'h0, ctl_vec()}, 32'h0);
        chk("ld_scnt", stall_cnt_o, 32'd6);

        // Jump beats load-use
        next_cyc();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_2000;
        ld_use_i    = 1'b1;
        settle();
        chk("jl_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b000111});
        chk("jl_addr", redirect_addr_o, 32'h0000_2000);
        next_cyc();
        idle_inputs();
        settle();
        chk("jl_scnt", stall_cnt_o, 32'd6);
        chk("jl_fcnt", {16'h0, flush_cnt_o}, 32'h3);

        // Fetch miss for two cycles
        next_cyc();
        imem_ready_i = 1'b0;
        settle();
        chk("if_c1", {26'h0, ctl_vec()}, {26'h0, 6'b100100});
        next_cyc();
        settle();
        chk("if_c2", {26'h0, ctl_vec()}, {26'h0, 6'b100100});
        next_cyc();
        imem_ready_i = 1'b1;
        settle();
        chk("if_ret", {26'h0, ctl_vec()}, 32'h0);
        chk("if_scnt", stall_cnt_o, 32'd8);

        // Stall counter saturation from a preloaded value
        next_cyc();
        force dut.u_stall_cnt.cnt = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt;
        chk("sat_pre", stall_cnt_o, 32'hFFFF_FFFE);
        ld_use_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
        end
        ld_use_i = 1'b0;
        settle();
        chk("sat_hold", stall_cnt_o, 32'hFFFF_FFFF);
        next_cyc();
        settle();
        chk("sat_idle", stall_cnt_o, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a mul/div wait
        next_cyc();
        md_start_i = 1'b1;
        next_cyc();
        md_start_i = 1'b0;
        settle();
        chk("ar_wait_ctl", {26'h0, ctl_vec()}, {26'h0, 6'b111000});
        rst = 1'b1;
        #1;
        chk("ar_ctl", {26'h0, ctl_vec()}, 32'h0);
        chk("ar_addr", redirect_addr_o, 32'h0);
        chk("ar_scnt", stall_cnt_o, 32'h0);
        chk("ar_fcnt", {16'h0, flush_cnt_o}, 32'h0);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        settle();
        chk("ar_run_ctl", {26'h0, ctl_vec()}, 32'h0);
        chk("ar_run_scnt", stall_cnt_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
